// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the writeback requesters and the register-file write arbiter.
// The slave modport is the arbiter's view, the master modport the requesters' side.
interface regfile_wb_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_data;
    logic                wb_stall;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DW-1:0]       wd;
    logic [GW-1:0]       grant_id;
    logic                busy;

    modport slave (
        input  req_valid, req_addr, req_data, wb_stall,
        output req_ready, we, wa, wd, grant_id, busy
    );

    modport master (
        output req_valid, req_addr, req_data, wb_stall,
        input  req_ready, we, wa, wd, grant_id, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between N_REQ
// writeback sources. One registered write stage, x0 writes are accepted but
// not written, and wb_stall blocks new grants without disturbing a write
// already in the stage.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [GW-1:0]    r_rr_ptr;
    logic             r_we;
    logic [AW-1:0]    r_wa;
    logic [DW-1:0]    r_wd;
    logic [GW-1:0]    r_grant_id;

    logic [GW-1:0]    w_winner;
    logic             w_found;
    logic             w_xfer;
    logic [N_REQ-1:0] w_ready;
    logic [AW-1:0]    w_addr_arr [N_REQ];
    logic [DW-1:0]    w_data_arr [N_REQ];
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_data;
    logic [GW-1:0]    w_ptr_next;

    // Unpack the flat address/data buses into per-requester lanes, and
    // raise ready only for the winning lane when a transfer is allowed.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign w_addr_arr[gi] = bus.req_addr[gi*AW +: AW];
            assign w_data_arr[gi] = bus.req_data[gi*DW +: DW];
            assign w_ready[gi]    = w_xfer && (w_winner == GW'(gi));
        end
    endgenerate

    // Find the first valid requester starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = GW'(idx);
            end
        end
    end

    // Reset gates ready so nothing accepted during reset can reach the write stage.
    assign w_xfer     = w_found && !bus.wb_stall && !rst;
    assign w_sel_addr = w_addr_arr[w_winner];
    assign w_sel_data = w_data_arr[w_winner];
    assign w_ptr_next = (w_winner == GW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;

    // Write stage and round-robin pointer: load on a transfer, otherwise
    // drop we and hold address/data/id so the last write stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_we       <= (w_sel_addr != '0);
            r_wa       <= w_sel_addr;
            r_wd       <= w_sel_data;
            r_grant_id <= w_winner;
            r_rr_ptr   <= w_ptr_next;
        end else begin
            r_we       <= 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.we        = r_we;
    assign bus.wa        = r_wa;
    assign bus.wd        = r_wd;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (|bus.req_valid) | r_we;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/wa/wd) between N_REQ writeback requesters, e.g. ALU, load unit and multiply/CSR unit.
- Uses round-robin arbitration, a per-requester valid/ready handshake, a registered write stage, x0 write suppression and a global stall input.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  requester i has a write pending.
- req_ready  output  N_REQ  requester i's transfer is accepted this cycle.
- req_addr  input  N_REQ*AW  destination register, requester i in bits [i*AW +: AW].
- req_data  input  N_REQ*DW  write data, requester i in bits [i*DW +: DW].
- wb_stall  input  1  when high, no grant is issued.
- we  output  1  register-file write enable (registered).
- wa  output  AW  register-file write address (registered).
- wd  output  DW  register-file write data (registered).
- grant_id  output  $clog2(N_REQ)  index of the requester that produced the current we/wa/wd (registered).
- busy  output  1  high when any req_valid is high or we is high.

Behaviour:
- Reset (rst high at a clock edge): we=0, wa=0, wd=0, grant_id=0, rr_ptr=0. While rst is high, req_ready=0 for all requesters. A transfer accepted in the same cycle as reset is discarded and never written.
- Arbitration (combinational):
  - Eligible set is {i : req_valid[i]=1}.
  - Search starts at rr_ptr and wraps modulo N_REQ. The first eligible index is the winner.
  - req_ready[winner]=1 only when wb_stall=0 and rst=0. All other req_ready bits are 0. At most one req_ready bit is high per cycle.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - A requester holds req_valid, req_addr and req_data stable until its transfer occurs. Dropping valid before that is a protocol violation; the block need not detect it.
- Pointer update: on a transfer by winner w, rr_ptr <= (w+1) mod N_REQ. With no transfer, rr_ptr holds. Wrap: w=N_REQ-1 gives rr_ptr=0.
- Write stage, one cycle latency:
  - On a transfer, the next edge loads wa<=req_addr[w], wd<=req_data[w] and grant_id<=w.
  - we <= 1 if req_addr[w] != 0, else we <= 0. An x0 write is accepted and dropped.
  - With no transfer, the next edge sets we<=0. wa, wd and grant_id hold their previous values.
- Throughput: one accepted write per cycle, back-to-back, with no bubbles.
- Fairness: a continuously valid requester is granted within N_REQ cycles while wb_stall=0.
- wb_stall:
  - Suppresses new grants only.
  - A write already registered (we=1) still completes on the edge after it was accepted.
  - rr_ptr does not move while stalled.
- Simultaneous requests:
  - Several requesters may target the same register. They are serialized in grant order; the last granted wins in the register file.
  - Requester-internal order is preserved because each requester has a single handshake.
- busy is combinational: OR of req_valid, OR'd with we.
- No internal buffering beyond the single write stage. The block contains no register-file storage.

Test Plan:
- Reset sequence: assert rst 2 cycles with req_valid=3'b111. Required: req_ready=0 throughout, we=0, wa=0, wd=0. On the first cycle after rst deasserts, requester 0 is granted.
- Single request: req0 addr=5, data=0xDEADBEEF for one cycle. Required: req_ready[0]=1 that cycle; next cycle we=1, wa=5, wd=0xDEADBEEF, grant_id=0; the cycle after, we=0.
- Round-robin contention: all three requesters valid continuously with addrs 1, 2, 3. Required: grant order 0,1,2,0,1,2; we=1 on every cycle from the second onward; wa sequence 1,2,3,1,…
- Wrap and fairness: rr_ptr=2 after granting 1; then req0 and req2 are valid. Required: req2 is granted first, then req0, and rr_ptr returns to 1.
- x0 suppression: req1 writes addr=0, data=0x1234. Required: req_ready[1]=1, the next cycle has we=0 and grant_id=1, and rr_ptr advances to 2.
- Stall and reset mid-operation:
  - Stall: hold wb_stall=1 for 3 cycles with req0 valid. Required: req_ready=0 and rr_ptr unchanged; an in-flight write accepted in the cycle before the stall still produces we=1.
  - Reset mid-operation: assert rst in the same cycle as a transfer. Required: the next cycle has we=0.
